// File: rtl/dmux_pkg.sv
// dmux_pkg
//   Shared definitions for the dmux family (sync_dmux_fifo, async_dmux_*).
//   Holds the default data width and depth, plus a constant-evaluable ceil(log2)
//   used to size pointers at elaboration time.
package dmux_pkg;

  localparam int DMUX_DW    = 32;
  localparam int DMUX_DEPTH = 4;

  // Smallest r such that 2**r >= value. Returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_dmux_ram.sv
// sync_dmux_ram
//   DEPTH x DW register array backing the FIFO. Storage is intentionally not
//   reset; validity of each slot is tracked by the pointers in the parent.
// Ports
//   clk    in   1     rising-edge clock
//   we     in   1     write enable
//   waddr  in   AW    write slot index
//   wdata  in   DW    write data
//   raddr  in   AW    read slot index
//   rdata  out  DW    combinational read data for raddr
module sync_dmux_ram
  import dmux_pkg::*;
#(
  parameter int DW    = DMUX_DW,
  parameter int DEPTH = DMUX_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_dmux_fifo.sv
// sync_dmux_fifo
//   Single-clock first-word-fall-through FIFO between a strobe-only producer
//   (val_d/d) and a consumer with backpressure (val_q/rdy_q). Holds up to DEPTH
//   words, reports occupancy, and latches a sticky overflow flag whenever a strobe
//   arrives with no room for it.
// Ports
//   clk      in   1     clock, all state on its rising edge
//   rstn     in   1     asynchronous active-low reset
//   val_d    in   1     producer strobe
//   d        in   DW    producer data
//   rdy_d    out  1     space available (!full); advisory only
//   val_q    out  1     head word valid (!empty)
//   q        out  DW    head word, 0 when empty
//   rdy_q    in   1     consumer takes head when val_q && rdy_q
//   count    out  AW+1  occupancy 0..DEPTH
//   ovf      out  1     sticky drop indicator
//   ovf_clr  in   1     synchronous clear of ovf (a same-cycle drop wins)
module sync_dmux_fifo
  import dmux_pkg::*;
#(
  parameter int  DW    = DMUX_DW,
  parameter int  DEPTH = DMUX_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          val_d,
  input  logic [DW-1:0] d,
  output logic          rdy_d,
  output logic          val_q,
  output logic [DW-1:0] q,
  input  logic          rdy_q,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the slot indices coincide.
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [DW-1:0] rdata;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  assign pop  = !empty && rdy_q;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wptr indexes, so the incoming word can be written there this cycle.
  assign push = val_d && (!full || pop);
  assign drop = val_d && full && !pop;

  sync_dmux_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr[AW-1:0]),
    .wdata (d),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + PTR_ONE;
    end else if (pop && !push) begin
      count <= count - PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Outputs derive only from registered pointers and storage, so reset clears
  // them immediately and no input reaches an output combinationally.
  assign rdy_d = !full;
  assign val_q = !empty;
  assign q     = empty ? '0 : rdata;

endmodule

// File: tb/tb_sync_dmux_fifo.sv
module tb_sync_dmux_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          val_d = 1'b0;
  logic [DW-1:0] d = '0;
  logic          rdy_q = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          rdy_d;
  logic          val_q;
  logic [DW-1:0] q;
  logic [AW:0]   count;
  logic          ovf;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of accepted words plus the sticky flag.
  logic [DW-1:0] mq [$];
  bit            m_ovf = 1'b0;

  sync_dmux_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .val_d   (val_d),
    .d       (d),
    .rdy_d   (rdy_d),
    .val_q   (val_q),
    .q       (q),
    .rdy_q   (rdy_q),
    .count   (count),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  function automatic void model_edge();
    bit pop_m, full_m, push_m, drop_m;
    if (!rstn) begin
      mq.delete();
      m_ovf = 1'b0;
      return;
    end
    pop_m  = (mq.size() > 0) && rdy_q;
    full_m = (mq.size() == DEPTH);
    push_m = val_d && (!full_m || pop_m);
    drop_m = val_d && full_m && !pop_m;
    if (drop_m) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (pop_m) void'(mq.pop_front());
    if (push_m) mq.push_back(d);
  endfunction

  function automatic logic [DW+AW+3:0] exp_vec();
    logic          e_val;
    logic [DW-1:0] e_q;
    e_val = (mq.size() != 0);
    e_q   = e_val ? mq[0] : '0;
    return {e_val, e_q, (AW+1)'(mq.size()), (mq.size() < DEPTH), m_ovf};
  endfunction

  function automatic logic [DW+AW+3:0] act_vec();
    return {val_q, q, count, rdy_d, ovf};
  endfunction

  function automatic string st();
    logic [DW+AW+3:0] e;
    e = exp_vec();
    return $sformatf("actual val_q=%0b q=%0h count=%0d rdy_d=%0b ovf=%0b, expected val_q=%0b q=%0h count=%0d rdy_d=%0b ovf=%0b",
                     val_q, q, count, rdy_d, ovf,
                     e[DW+AW+3], e[DW+AW+2:AW+3], e[AW+2:2], e[1], e[0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain();
    val_d = 1'b0; rdy_q = 1'b1; ovf_clr = 1'b1;
    repeat (DEPTH + 1) tick();
    ovf_clr = 1'b0; rdy_q = 1'b0;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    repeat (2) tick();
    checks++;
    if ({val_q, q, count, rdy_d, ovf} !== {1'b0, 32'h0, 3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_hold: %s", st());
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL reset_release: %s", st()); end
  endtask

  task automatic test_single();
    val_d = 1'b1; d = 32'h1; rdy_q = 1'b1;
    tick();
    val_d = 1'b0;
    checks++;
    if (val_q !== 1'b1 || q !== 32'h1 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL single_word: %s", st());
    end
    tick();
    checks++;
    if (val_q !== 1'b0 || count !== 3'd0 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL single_empty: %s", st());
    end
    rdy_q = 1'b0;
  endtask

  task automatic test_fill_overflow();
    rdy_q = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      val_d = 1'b1; d = DW'(i);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin errors++; $display("FAIL fill_%0d: %s", i, st()); end
      if (i == 4) begin
        checks++;
        if (count !== 3'd4 || rdy_d !== 1'b0 || ovf !== 1'b0) begin
          errors++; $display("FAIL fill_full: actual count=%0d rdy_d=%0b ovf=%0b, expected 4 0 0", count, rdy_d, ovf);
        end
      end
    end
    val_d = 1'b0;
    checks++;
    if (ovf !== 1'b1 || count !== 3'd4) begin
      errors++; $display("FAIL overflow_drop: actual ovf=%0b count=%0d, expected 1 4", ovf, count);
    end
    rdy_q = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (val_q !== 1'b1 || q !== DW'(i)) begin
        errors++; $display("FAIL drain_%0d: actual val_q=%0b q=%0h, expected 1 %0h", i, val_q, q, i);
      end
      tick();
    end
    checks++;
    if (val_q !== 1'b0 || act_vec() !== exp_vec()) begin errors++; $display("FAIL drain_empty: %s", st()); end
    drain();
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] seen [$];
    logic [DW-1:0] want [$];
    want = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h9};
    rdy_q = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      val_d = 1'b1; d = DW'(i);
      tick();
    end
    rdy_q = 1'b1; val_d = 1'b1; d = 32'h9;
    if (val_q) seen.push_back(q);
    tick();
    val_d = 1'b0;
    checks++;
    if (count !== 3'd4 || ovf !== 1'b0 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL full_push_pop: %s", st());
    end
    for (int k = 0; k < 10 && val_q; k++) begin
      seen.push_back(q);
      tick();
    end
    checks++;
    if (seen != want) begin
      errors++; $display("FAIL full_order: actual %p, expected %p", seen, want);
    end
    rdy_q = 1'b0;
  endtask

  task automatic test_wrap();
    rdy_q = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      val_d = 1'b1; d = DW'(i);
      tick();
      val_d = 1'b0;
      checks++;
      if (q !== DW'(i) || count > 3'd1 || ovf !== 1'b0 || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrap_%0d: %s", i, st());
      end
      tick();
      checks++;
      if (count > 3'd1 || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrap_gap_%0d: %s", i, st());
      end
    end
    rdy_q = 1'b0;
  endtask

  task automatic test_ovf_clr();
    rdy_q = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      val_d = 1'b1; d = $urandom;
      tick();
    end
    val_d = 1'b1; d = 32'h77; ovf_clr = 1'b1;
    tick();
    checks++;
    if (ovf !== 1'b1 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL ovf_set_wins: %s", st());
    end
    val_d = 1'b0;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL ovf_clear: %s", st());
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      val_d   = ($urandom_range(0, 3) != 0);
      d       = $urandom;
      rdy_q   = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin errors++; $display("FAIL random_%0d: %s", n, st()); end
    end
    drain();
  endtask

  task automatic test_mid_reset();
    rdy_q = 1'b0;
    for (int i = 0; i < 3; i++) begin
      val_d = 1'b1; d = 32'h100 + i;
      tick();
    end
    val_d = 1'b0;
    checks++;
    if (count !== 3'd3 || act_vec() !== exp_vec()) begin errors++; $display("FAIL mid_prefill: %s", st()); end
    #2 rstn = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0;
    checks++;
    if (val_q !== 1'b0 || count !== 3'd0 || q !== '0 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL mid_reset_async: %s", st());
    end
    tick();
    rstn = 1'b1;
    val_d = 1'b1; d = 32'hA;
    tick();
    val_d = 1'b0;
    checks++;
    if (val_q !== 1'b1 || q !== 32'hA || count !== 3'd1 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL mid_reset_first: %s", st());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_ovf_clr();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
